// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool with half-row line buffer and buffer-controller strobes.
// Optional POOL_RELU_EN clamps negative pooled results to zero.
module max_pool_2x2_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FM_WIDTH   = 22,
    parameter int FM_HEIGHT  = 22,
    parameter int X_BITS     = 5,
    parameter int Y_BITS     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pool_out,
    output logic                  pool_valid,
    output logic                  data_rdy,
    output logic [X_BITS:0]       xcoord,
    output logic [Y_BITS:0]       ycoord,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int LB_DEPTH = FM_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] m;
        if ($signed(a) > $signed(b)) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [X_BITS-1:0]     r_x;
    logic [Y_BITS-1:0]     r_y;
    logic [DATA_WIDTH-1:0] r_pair;
    logic [DATA_WIDTH-1:0] r_lb [0:LB_DEPTH-1];
    logic                  r_pix_ready;
    logic                  r_data_rdy;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_pool_out;
    logic                  r_pool_valid;
    logic [X_BITS:0]       r_xcoord;
    logic [Y_BITS:0]       r_ycoord;

    logic                  w_accept;
    logic                  w_x_last;
    logic                  w_y_last;
    logic                  w_frame_end;
    logic                  w_emit;
    logic [X_BITS-1:0]     w_half;
    logic [LB_AW-1:0]      w_lb_idx;
    logic [DATA_WIDTH-1:0] w_pair_max;
    logic [DATA_WIDTH-1:0] w_win_max;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_accept    = pix_valid & r_pix_ready;
    assign w_x_last    = (r_x == X_BITS'(FM_WIDTH - 1));
    assign w_y_last    = (r_y == Y_BITS'(FM_HEIGHT - 1));
    assign w_frame_end = w_x_last & w_y_last;
    assign w_emit      = w_accept & r_x[0] & r_y[0];
    assign w_half      = r_x >> 1;
    assign w_lb_idx    = w_half[LB_AW-1:0];
    assign w_pair_max  = smax(r_pair, pix_in);
    assign w_win_max   = smax(w_pair_max, r_lb[w_lb_idx]);

`ifdef POOL_RELU_EN
    assign w_result = w_win_max[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : w_win_max;
`else
    assign w_result = w_win_max;
`endif

    // Next-state decode; the final pixel of a frame forces FLUSH even from IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_frame_end ? S_FLUSH : S_ACTIVE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (w_accept && w_frame_end) begin
                    w_next = S_FLUSH;
                end else begin
                    w_next = S_ACTIVE;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Frame FSM with handshake/level outputs registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pix_ready  <= 1'b0;
            r_data_rdy   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_pix_ready  <= (w_next == S_IDLE) || (w_next == S_ACTIVE);
            r_data_rdy   <= (w_next == S_ACTIVE) || (w_next == S_FLUSH);
            r_frame_done <= (w_next == S_DONE);
        end
    end

    // Raster counters, pair register, line buffer and pooled output strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x          <= {X_BITS{1'b0}};
            r_y          <= {Y_BITS{1'b0}};
            r_pair       <= {DATA_WIDTH{1'b0}};
            r_pool_out   <= {DATA_WIDTH{1'b0}};
            r_pool_valid <= 1'b0;
            r_xcoord     <= {(X_BITS+1){1'b0}};
            r_ycoord     <= {(Y_BITS+1){1'b0}};
            for (int i = 0; i < LB_DEPTH; i++) begin
                r_lb[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (w_accept) begin
                if (w_x_last) begin
                    r_x <= {X_BITS{1'b0}};
                    r_y <= w_y_last ? {Y_BITS{1'b0}} : r_y + Y_BITS'(1);
                end else begin
                    r_x <= r_x + X_BITS'(1);
                end
                if (!r_x[0]) begin
                    r_pair <= pix_in;
                end else if (!r_y[0]) begin
                    r_lb[w_lb_idx] <= w_pair_max;
                end
            end
            // Coordinates are zero whenever no result is presented.
            r_pool_valid <= w_emit;
            r_xcoord     <= w_emit ? {1'b0, r_x} : {(X_BITS+1){1'b0}};
            r_ycoord     <= w_emit ? {1'b0, r_y} : {(Y_BITS+1){1'b0}};
            if (w_emit) begin
                r_pool_out <= w_result;
            end
        end
    end

    assign pix_ready  = r_pix_ready;
    assign data_rdy   = r_data_rdy;
    assign frame_done = r_frame_done;
    assign pool_out   = r_pool_out;
    assign pool_valid = r_pool_valid;
    assign xcoord     = r_xcoord;
    assign ycoord     = r_ycoord;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Scoreboard bench for max_pool_2x2_stream on a 4x4 feature map.
module tb_max_pool_2x2_stream;

    localparam int DW  = 16;
    localparam int FMW = 4;
    localparam int FMH = 4;
    localparam int XB  = 2;
    localparam int YB  = 2;

    typedef struct {
        longint v;
        int     x;
        int     y;
        int     cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] pool_out;
    logic          pool_valid;
    logic          data_rdy;
    logic [XB:0]   xcoord;
    logic [YB:0]   ycoord;
    logic          frame_done;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     n_out = 0;
    exp_t   sb_q[$];
    int     m_x = 0;
    int     m_y = 0;
    longint m_pair = 0;
    longint m_lb [0:FMW/2-1];

    max_pool_2x2_stream #(
        .DATA_WIDTH(DW), .FM_WIDTH(FMW), .FM_HEIGHT(FMH), .X_BITS(XB), .Y_BITS(YB)
    ) dut (
        .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pool_out(pool_out), .pool_valid(pool_valid),
        .data_rdy(data_rdy), .xcoord(xcoord), .ycoord(ycoord), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lmax(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_clear();
        m_x = 0;
        m_y = 0;
        m_pair = 0;
        sb_q.delete();
    endtask

    // Reference pooling model; the accept happens on the coming rising edge.
    task automatic model_accept(input longint v);
        longint p;
        longint r;
        exp_t   e;
        if (m_x % 2 == 1) begin
            p = lmax(m_pair, v);
            if (m_y % 2 == 0) begin
                m_lb[m_x/2] = p;
            end else begin
                r = lmax(p, m_lb[m_x/2]);
`ifdef POOL_RELU_EN
                if (r < 0) r = 0;
`endif
                e.v = r; e.x = m_x; e.y = m_y; e.cyc = cyc + 1;
                sb_q.push_back(e);
            end
        end else begin
            m_pair = v;
        end
        m_x++;
        if (m_x == FMW) begin
            m_x = 0;
            m_y++;
            if (m_y == FMH) m_y = 0;
        end
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    always @(negedge clock) begin
        if (!reset) begin
            if (pool_valid) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("extra_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("pool_out", longint'($signed(pool_out)), e.v);
                    chk("xcoord", xcoord, e.x);
                    chk("ycoord", ycoord, e.y);
                    chk("latency", cyc, e.cyc);
                end
            end else begin
                chk("xcoord_idle", xcoord, 0);
                chk("ycoord_idle", ycoord, 0);
            end
        end
    end

    // Called at a falling edge; returns at a falling edge after the accept and stalls.
    task automatic send(input longint v, input int stall);
        int t;
        t = 0;
        while (!pix_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("ready_wait", pix_ready, 1);
        pix_in    = DW'(v);
        pix_valid = 1'b1;
        model_accept(v);
        @(negedge clock);
        pix_valid = 1'b0;
        chk("data_rdy_act", data_rdy, 1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            chk("data_rdy_stall", data_rdy, 1);
            chk("pool_valid_stall", pool_valid, 0);
        end
    endtask

    function automatic longint pix_val(input int mode, input int base, input int i);
        if (mode == 1) return (i == 14) ? -1 : -3;
        return base + i;
    endfunction

    task automatic run_frame(input int mode, input int base, input int stall);
        n_out = 0;
        for (int i = 0; i < FMW*FMH; i++) begin
            send(pix_val(mode, base, i), (i == FMW*FMH-1) ? 0 : stall);
        end
        chk("flush_ready", pix_ready, 0);
        chk("flush_data_rdy", data_rdy, 1);
        chk("flush_done", frame_done, 0);
        @(negedge clock);
        chk("done_pulse", frame_done, 1);
        chk("done_data_rdy", data_rdy, 0);
        chk("done_ready", pix_ready, 0);
        chk("sb_empty", sb_q.size(), 0);
        chk("n_out", n_out, (FMW/2)*(FMH/2));
        @(negedge clock);
        chk("done_clear", frame_done, 0);
        chk("idle_ready", pix_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_pool_valid", pool_valid, 0);
        chk("rst_pool_out", pool_out, 0);
        chk("rst_data_rdy", data_rdy, 0);
        chk("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready_rst", pix_ready, 1);
        chk("idle_data_rdy", data_rdy, 0);

        // Raster 0..15, streaming.
        run_frame(0, 0, 0);
        // Negative data with one larger pixel in the last window.
        run_frame(1, 0, 0);
        // Stalls of three cycles after every accept.
        run_frame(0, 0, 3);

        // Reset in the middle of a frame.
        for (int i = 0; i < 9; i++) begin
            send(longint'(i), 0);
        end
        chk("pre_rst_data_rdy", data_rdy, 1);
        reset = 1'b1;
        #1;
        chk("amid_pool_out", pool_out, 0);
        chk("amid_pool_valid", pool_valid, 0);
        chk("amid_data_rdy", data_rdy, 0);
        chk("amid_xcoord", xcoord, 0);
        chk("amid_ycoord", ycoord, 0);
        chk("amid_frame_done", frame_done, 0);
        chk("amid_pix_ready", pix_ready, 0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_frame(0, 0, 0);

        // Back-to-back frames; run_frame verifies exactly two not-ready cycles.
        run_frame(0, 100, 0);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
